// File: rtl/nabp_sinogram_fetcher.sv
// nabp_sinogram_fetcher
// Sweeps the sinogram in passes of NUM_CHANNELS angles. Each issue cycle reads one projection
// line from NUM_CHANNELS parallel RAM ports of fixed latency. The returned samples are re-aligned
// with their tags and buffered in a credit-limited skid FIFO. The FIFO head feeds the processing
// elements over a valid/ready stream.
//
// Ports:
//   clk, reset_n   - clock and asynchronous active-low reset
//   sg_kick        - host start pulse, honoured only while idle
//   sg_addr/sg_rd  - per-lane RAM address and common read strobe
//   sg_val         - per-lane RAM data, valid RAM_LATENCY cycles after sg_rd
//   pe_valid/pe_ready, pe_val, pe_lane_mask, pe_angle_base, pe_proj, pe_last - output stream
//   sg_busy        - sweep in progress
//   sg_done        - one-cycle completion pulse
module nabp_sinogram_fetcher #(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned NUM_ANGLES   = 180,
  parameter int unsigned NUM_PROJ     = 256,
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned RAM_LATENCY  = 1,
  parameter int unsigned ADDR_W       = (NUM_ANGLES * NUM_PROJ > 1) ?
                                        $clog2(NUM_ANGLES * NUM_PROJ) : 1,
  parameter int unsigned FIFO_DEPTH   = RAM_LATENCY + 2,
  localparam int unsigned AngW        = (NUM_ANGLES > 1) ? $clog2(NUM_ANGLES) : 1,
  localparam int unsigned ProjW       = (NUM_PROJ > 1) ? $clog2(NUM_PROJ) : 1
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             sg_kick,
  output logic [NUM_CHANNELS*ADDR_W-1:0]   sg_addr,
  output logic                             sg_rd,
  input  logic [NUM_CHANNELS*DATA_W-1:0]   sg_val,
  output logic                             pe_valid,
  input  logic                             pe_ready,
  output logic [NUM_CHANNELS*DATA_W-1:0]   pe_val,
  output logic [NUM_CHANNELS-1:0]          pe_lane_mask,
  output logic [AngW-1:0]                  pe_angle_base,
  output logic [ProjW-1:0]                 pe_proj,
  output logic                             pe_last,
  output logic                             sg_busy,
  output logic                             sg_done
);

  // angle_base of the final pass
  localparam int unsigned LastBase = ((NUM_ANGLES - 1) / NUM_CHANNELS) * NUM_CHANNELS;
  localparam int unsigned PtrW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW     = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

  typedef struct packed {
    logic [NUM_CHANNELS-1:0] mask;
    logic [AngW-1:0]         angle;
    logic [ProjW-1:0]        proj;
    logic                    last;
  } tag_t;

  typedef struct packed {
    logic [NUM_CHANNELS*DATA_W-1:0] data;
    tag_t                           tag;
  } entry_t;

  state_e                 state_q, state_d;
  logic [AngW-1:0]        angle_q, angle_d;
  logic [ProjW-1:0]       proj_q, proj_d;
  logic [RAM_LATENCY-1:0] pipe_vld_q;
  tag_t                   pipe_tag_q [RAM_LATENCY];
  entry_t                 fifo_q [FIFO_DEPTH];
  logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]        count_q, count_d;

  logic        issue, last_pair, push, pop;
  tag_t        issue_tag;
  entry_t      head;
  int unsigned inflight;
  logic [31:0]       lane_angle;
  logic [ADDR_W-1:0] lane_addr;

  // Reads still travelling through the RAM; together with FIFO occupancy these are the
  // credits in use, so a full FIFO can always absorb every outstanding return.
  always_comb begin
    inflight = 0;
    for (int i = 0; i < RAM_LATENCY; i++) begin
      inflight = inflight + {31'b0, pipe_vld_q[i]};
    end
  end

  assign last_pair = (32'(angle_q) == LastBase) && (32'(proj_q) == NUM_PROJ - 1);
  assign issue     = (state_q == StFetch) && ((inflight + 32'(count_q)) < FIFO_DEPTH);
  assign sg_rd     = issue;

  // Lane addresses and the tag travelling alongside the read.
  always_comb begin
    sg_addr         = '0;
    issue_tag       = '0;
    issue_tag.angle = angle_q;
    issue_tag.proj  = proj_q;
    issue_tag.last  = last_pair;
    lane_angle      = '0;
    lane_addr       = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      lane_angle = 32'(angle_q) + 32'(c);
      lane_addr  = ADDR_W'(lane_angle * NUM_PROJ + 32'(proj_q));
      // Lanes past the last angle read address 0 and are masked off.
      if (lane_angle < NUM_ANGLES) begin
        issue_tag.mask[c] = 1'b1;
        if (issue) begin
          sg_addr[c*ADDR_W +: ADDR_W] = lane_addr;
        end
      end
    end
  end

  // Sweep control and index counters.
  always_comb begin
    state_d = state_q;
    angle_d = angle_q;
    proj_d  = proj_q;
    case (state_q)
      StIdle: begin
        if (sg_kick) begin
          state_d = StFetch;
          angle_d = '0;
          proj_d  = '0;
        end
      end
      StFetch: begin
        if (issue) begin
          if (last_pair) begin
            state_d = StDrain;
          end else if (32'(proj_q) == NUM_PROJ - 1) begin
            proj_d  = '0;
            angle_d = AngW'(32'(angle_q) + NUM_CHANNELS);
          end else begin
            proj_d = proj_q + 1'b1;
          end
        end
      end
      StDrain: begin
        if (pop && head.tag.last) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Skid FIFO bookkeeping.
  assign push     = pipe_vld_q[RAM_LATENCY-1];
  assign head     = fifo_q[rd_ptr_q];
  assign pe_valid = (count_q != '0);
  assign pop      = pe_valid && pe_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = (32'(wr_ptr_q) == FIFO_DEPTH - 1) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (32'(rd_ptr_q) == FIFO_DEPTH - 1) ? '0 : rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      angle_q    <= '0;
      proj_q     <= '0;
      pipe_vld_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q       <= state_d;
      angle_q       <= angle_d;
      proj_q        <= proj_d;
      pipe_vld_q[0] <= issue;
      for (int i = 1; i < RAM_LATENCY; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: validity is carried by pipe_vld_q and count_q.
  always_ff @(posedge clk) begin
    pipe_tag_q[0] <= issue_tag;
    for (int i = 1; i < RAM_LATENCY; i++) begin
      pipe_tag_q[i] <= pipe_tag_q[i-1];
    end
    if (push) begin
      fifo_q[wr_ptr_q] <= {sg_val, pipe_tag_q[RAM_LATENCY-1]};
    end
  end

  // Payload is forced to zero while no beat is presented.
  assign pe_val        = pe_valid ? head.data      : '0;
  assign pe_lane_mask  = pe_valid ? head.tag.mask  : '0;
  assign pe_angle_base = pe_valid ? head.tag.angle : '0;
  assign pe_proj       = pe_valid ? head.tag.proj  : '0;
  assign pe_last       = pe_valid ? head.tag.last  : 1'b0;

  assign sg_busy = (state_q == StFetch) || (state_q == StDrain);
  assign sg_done = (state_q == StDone);

  // Credits bound occupancy, so a push into a full FIFO without a pop is a design error.
  fifo_no_overflow_a: assert property (@(posedge clk) disable iff (!reset_n)
    !(push && !pop && (32'(count_q) == FIFO_DEPTH)));

endmodule

// File: tb/tb_nabp_sinogram_fetcher.sv
// Testbench for nabp_sinogram_fetcher: a 5-angle/4-projection/2-lane/latency-2 instance and a
// degenerate 1x1x1 latency-1 instance, each fed by a RAM model that returns its address as data.
`timescale 1ns/1ps
module tb_nabp_sinogram_fetcher;
  localparam int unsigned DataW = 16;
  localparam int unsigned NA    = 5;
  localparam int unsigned NP    = 4;
  localparam int unsigned NC    = 2;
  localparam int unsigned Lat   = 2;
  localparam int unsigned AddrW = $clog2(NA * NP);
  localparam int unsigned AngW  = $clog2(NA);
  localparam int unsigned ProjW = $clog2(NP);
  localparam int unsigned Depth = Lat + 2;
  localparam int          Beats = ((NA + NC - 1) / NC) * NP;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // Main instance
  logic                   sg_kick, sg_rd, pe_valid, pe_ready, pe_last, sg_busy, sg_done;
  logic [NC*AddrW-1:0]    sg_addr;
  logic [NC*DataW-1:0]    sg_val, pe_val;
  logic [NC-1:0]          pe_lane_mask;
  logic [AngW-1:0]        pe_angle_base;
  logic [ProjW-1:0]       pe_proj;

  nabp_sinogram_fetcher #(
    .DATA_W(DataW), .NUM_ANGLES(NA), .NUM_PROJ(NP), .NUM_CHANNELS(NC), .RAM_LATENCY(Lat)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .sg_kick(sg_kick), .sg_addr(sg_addr), .sg_rd(sg_rd),
    .sg_val(sg_val), .pe_valid(pe_valid), .pe_ready(pe_ready), .pe_val(pe_val),
    .pe_lane_mask(pe_lane_mask), .pe_angle_base(pe_angle_base), .pe_proj(pe_proj),
    .pe_last(pe_last), .sg_busy(sg_busy), .sg_done(sg_done)
  );

  // RAM model: data = address, junk when not read.
  logic [NC*DataW-1:0] ram_pipe [Lat];
  always @(posedge clk) begin
    for (int s = Lat - 1; s > 0; s--) ram_pipe[s] <= ram_pipe[s-1];
    for (int c = 0; c < NC; c++)
      ram_pipe[0][c*DataW +: DataW] <= sg_rd ? DataW'(sg_addr[c*AddrW +: AddrW])
                                             : DataW'($urandom);
  end
  assign sg_val = ram_pipe[Lat-1];

  // Tiny instance
  logic             t_kick, t_rd, t_valid, t_ready, t_last, t_busy, t_done;
  logic [0:0]       t_addr, t_mask, t_angle, t_proj;
  logic [DataW-1:0] t_val, t_pe_val;

  nabp_sinogram_fetcher #(
    .DATA_W(DataW), .NUM_ANGLES(1), .NUM_PROJ(1), .NUM_CHANNELS(1), .RAM_LATENCY(1)
  ) u_tiny (
    .clk(clk), .reset_n(reset_n), .sg_kick(t_kick), .sg_addr(t_addr), .sg_rd(t_rd),
    .sg_val(t_val), .pe_valid(t_valid), .pe_ready(t_ready), .pe_val(t_pe_val),
    .pe_lane_mask(t_mask), .pe_angle_base(t_angle), .pe_proj(t_proj),
    .pe_last(t_last), .sg_busy(t_busy), .sg_done(t_done)
  );

  always @(posedge clk) t_val <= t_rd ? DataW'(t_addr) : DataW'($urandom);

  int n_checks = 0;
  int n_pass   = 0;

  // Reference: beat k belongs to pass k/NP at projection k%NP.
  function automatic void exp_beat(input int k, output logic [NC*DataW-1:0] v,
                                   output logic [NC-1:0] m, output int ang, output int pj,
                                   output logic lst);
    int base;
    base = (k / NP) * NC;
    pj   = k % NP;
    ang  = base;
    lst  = (k == Beats - 1);
    v    = '0;
    m    = '0;
    for (int c = 0; c < NC; c++) begin
      if (base + c < NA) begin
        m[c] = 1'b1;
        v[c*DataW +: DataW] = DataW'((base + c) * NP + pj);
      end
    end
  endfunction

  typedef struct {
    logic [NC*DataW-1:0] v;
    logic [NC-1:0]       m;
    int                  ang;
    int                  pj;
    logic                lst;
    int                  cyc;
  } beat_t;

  beat_t beats_q[$];
  int n_issue, n_done, first_rd, first_vld, done_cyc, max_out, unstable, rd_after_done;
  bit timed_out, busy_c0;

  task automatic kick_main();
    sg_kick = 1'b1;
    @(posedge clk); #1;
    sg_kick = 1'b0;
  endtask

  // Observes the main instance cycle by cycle; policy 0 = ready, 1 = 10-cycle stall after first
  // valid, 2 = random ready. Stops after abort_at beats (if >0) or 20 cycles after sg_done.
  task automatic collect(input int policy, input int abort_at, input bit kick_mid);
    int    cyc, tail;
    bit    held;
    beat_t hb, b;
    beats_q.delete();
    n_issue = 0; n_done = 0; first_rd = -1; first_vld = -1; done_cyc = -1;
    max_out = 0; unstable = 0; rd_after_done = 0; timed_out = 0; busy_c0 = sg_busy;
    cyc = 0; tail = -1; held = 0;
    hb = '{v: '0, m: '0, ang: 0, pj: 0, lst: 1'b0, cyc: 0};
    forever begin
      if (first_vld < 0 && pe_valid) first_vld = cyc;
      case (policy)
        0:       pe_ready = 1'b1;
        1:       pe_ready = !(first_vld >= 0 && cyc < first_vld + 10);
        default: pe_ready = ($urandom_range(1, 0) == 1);
      endcase
      if (held && (!pe_valid || pe_val !== hb.v || pe_lane_mask !== hb.m ||
                   int'(pe_angle_base) != hb.ang || int'(pe_proj) != hb.pj ||
                   pe_last !== hb.lst)) unstable++;
      held = pe_valid && !pe_ready;
      b.v = pe_val; b.m = pe_lane_mask; b.ang = int'(pe_angle_base); b.pj = int'(pe_proj);
      b.lst = pe_last; b.cyc = cyc;
      if (held) hb = b;
      if (kick_mid) sg_kick = (cyc == 3) || sg_done;
      if (sg_rd) begin
        if (first_rd < 0) first_rd = cyc;
        n_issue++;
        if (n_done > 0) rd_after_done++;
        if (n_issue - beats_q.size() > max_out) max_out = n_issue - beats_q.size();
      end
      if (pe_valid && pe_ready) beats_q.push_back(b);
      if (sg_done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (abort_at > 0 && beats_q.size() == abort_at) break;
      if (tail < 0 && n_done > 0) tail = 20;
      if (tail == 0) break;
      if (tail > 0) tail--;
      if (cyc >= 2000) begin
        timed_out = 1;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    sg_kick = 1'b0;
  endtask

  task automatic check_sequence(input string tag);
    logic [NC*DataW-1:0] ev;
    logic [NC-1:0]       em;
    int                  ea, ep;
    logic                el;
    n_checks++;
    if (timed_out) $display("FAIL %s_timeout: got no sg_done within budget, required completion",
                            tag);
    else n_pass++;
    n_checks++;
    if (beats_q.size() != Beats)
      $display("FAIL %s_beat_count: got %0d, required %0d", tag, beats_q.size(), Beats);
    else n_pass++;
    for (int k = 0; k < Beats; k++) begin
      exp_beat(k, ev, em, ea, ep, el);
      n_checks++;
      if (k >= beats_q.size())
        $display("FAIL %s_beat%0d: got nothing, required data %h", tag, k, ev);
      else if (beats_q[k].v !== ev || beats_q[k].m !== em || beats_q[k].ang != ea ||
               beats_q[k].pj != ep || beats_q[k].lst !== el)
        $display("FAIL %s_beat%0d: got data %h mask %b ang %0d proj %0d last %b, required %h %b %0d %0d %b",
                 tag, k, beats_q[k].v, beats_q[k].m, beats_q[k].ang, beats_q[k].pj,
                 beats_q[k].lst, ev, em, ea, ep, el);
      else n_pass++;
    end
    n_checks++;
    if (n_done != 1) $display("FAIL %s_done_count: got %0d, required 1", tag, n_done);
    else n_pass++;
  endtask

  task automatic check_outputs_zero(input string tag);
    n_checks++;
    if ({sg_rd, sg_addr} !== '0)
      $display("FAIL %s_rd_addr: got rd %b addr %h, required 0", tag, sg_rd, sg_addr);
    else n_pass++;
    n_checks++;
    if (pe_valid !== 1'b0) $display("FAIL %s_pe_valid: got %b, required 0", tag, pe_valid);
    else n_pass++;
    n_checks++;
    if ({pe_val, pe_lane_mask, pe_angle_base, pe_proj, pe_last} !== '0)
      $display("FAIL %s_payload: got val %h mask %b ang %0d proj %0d last %b, required 0",
               tag, pe_val, pe_lane_mask, pe_angle_base, pe_proj, pe_last);
    else n_pass++;
    n_checks++;
    if ({sg_busy, sg_done} !== 2'b00)
      $display("FAIL %s_busy_done: got %b%b, required 00", tag, sg_busy, sg_done);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; sg_kick = 1'b0; pe_ready = 1'b0; t_kick = 1'b0; t_ready = 1'b0;
    #1;
    check_outputs_zero("reset");
    n_checks++;
    if ({t_valid, t_rd, t_busy, t_done, t_pe_val} !== '0)
      $display("FAIL reset_tiny: got valid %b rd %b busy %b done %b val %h, required 0",
               t_valid, t_rd, t_busy, t_done, t_pe_val);
    else n_pass++;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_free_run();
    kick_main();
    collect(0, 0, 0);
    check_sequence("free");
    n_checks++;
    if (first_rd != 0) $display("FAIL free_first_rd: got cycle %0d, required 0", first_rd);
    else n_pass++;
    n_checks++;
    if (busy_c0 !== 1'b1) $display("FAIL free_busy: got %b, required 1", busy_c0);
    else n_pass++;
    n_checks++;
    if (first_vld != Lat + 1)
      $display("FAIL free_first_valid: got cycle %0d, required %0d", first_vld, Lat + 1);
    else n_pass++;
    for (int k = 1; k < beats_q.size(); k++) begin
      n_checks++;
      if (beats_q[k].cyc != beats_q[0].cyc + k)
        $display("FAIL free_gap%0d: got cycle %0d, required %0d", k, beats_q[k].cyc,
                 beats_q[0].cyc + k);
      else n_pass++;
    end
    if (beats_q.size() > 0) begin
      n_checks++;
      if (done_cyc != beats_q[beats_q.size()-1].cyc + 1)
        $display("FAIL free_done_cycle: got %0d, required %0d", done_cyc,
                 beats_q[beats_q.size()-1].cyc + 1);
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    kick_main();
    collect(1, 0, 0);
    check_sequence("stall");
    n_checks++;
    if (max_out != Depth)
      $display("FAIL stall_outstanding: got max %0d, required %0d", max_out, Depth);
    else n_pass++;
    n_checks++;
    if (unstable != 0) $display("FAIL stall_stable: got %0d changes, required 0", unstable);
    else n_pass++;
  endtask

  task automatic test_random_ready();
    for (int r = 0; r < 3; r++) begin
      kick_main();
      collect(2, 0, 0);
      check_sequence("random");
      n_checks++;
      if (unstable != 0) $display("FAIL random_stable: got %0d changes, required 0", unstable);
      else n_pass++;
      n_checks++;
      if (max_out > Depth)
        $display("FAIL random_outstanding: got max %0d, required <= %0d", max_out, Depth);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_sweep();
    int stale;
    kick_main();
    collect(0, 5, 0);
    n_checks++;
    if (beats_q.size() != 5)
      $display("FAIL midrst_prefix: got %0d beats, required 5", beats_q.size());
    else n_pass++;
    reset_n = 1'b0;
    #1;
    check_outputs_zero("midrst");
    @(posedge clk); @(posedge clk); #1;
    check_outputs_zero("midrst_hold");
    reset_n = 1'b1;
    stale = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (pe_valid || sg_rd || sg_busy || sg_done) stale++;
    end
    n_checks++;
    if (stale != 0) $display("FAIL midrst_stale: got %0d active cycles, required 0", stale);
    else n_pass++;
    kick_main();
    collect(0, 0, 0);
    check_sequence("midrst_rerun");
  endtask

  task automatic test_kick_ignored();
    kick_main();
    collect(0, 0, 1);
    check_sequence("kick");
    n_checks++;
    if (n_issue != Beats) $display("FAIL kick_issues: got %0d, required %0d", n_issue, Beats);
    else n_pass++;
    n_checks++;
    if (rd_after_done != 0 || sg_busy !== 1'b0)
      $display("FAIL kick_restart: got %0d reads after done busy %b, required 0 0",
               rd_after_done, sg_busy);
    else n_pass++;
  endtask

  task automatic test_single_channel();
    int         vcyc, dcyc, nb;
    logic       rd0;
    logic [0:0] a0;
    logic [DataW-1:0] bv;
    logic       bl, bm;
    t_ready = 1'b1;
    t_kick  = 1'b1;
    @(posedge clk); #1;
    t_kick = 1'b0;
    rd0 = t_rd; a0 = t_addr; vcyc = -1; dcyc = -1; nb = 0; bv = '1; bl = 1'b0; bm = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (t_valid && vcyc < 0) vcyc = cyc;
      if (t_valid && t_ready) begin
        nb++;
        bv = t_pe_val; bl = t_last; bm = t_mask[0];
      end
      if (t_done && dcyc < 0) dcyc = cyc;
      @(posedge clk); #1;
    end
    n_checks++;
    if (rd0 !== 1'b1 || a0 !== 1'b0)
      $display("FAIL tiny_issue: got rd %b addr %0d, required 1 0", rd0, a0);
    else n_pass++;
    n_checks++;
    if (vcyc != 2) $display("FAIL tiny_latency: got cycle %0d, required 2", vcyc);
    else n_pass++;
    n_checks++;
    if (nb != 1 || bv !== '0 || bl !== 1'b1 || bm !== 1'b1)
      $display("FAIL tiny_beat: got %0d beats data %h last %b mask %b, required 1 0 1 1",
               nb, bv, bl, bm);
    else n_pass++;
    n_checks++;
    if (dcyc != 3) $display("FAIL tiny_done: got cycle %0d, required 3", dcyc);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stall();
    test_random_ready();
    test_reset_mid_sweep();
    test_kick_ignored();
    test_single_channel();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
